// File: rtl/timer_loader_if.sv
// timer_loader_if: bundle between the keypad/timer side and timer_loader.
//   Keypad side : key_valid, key_code, start, stop (and door_open when
//                 TIMER_LOADER_DOOR_EN is defined)
//   Timer side  : zero (from timer); data, loadn, clrn, enable (to timer)
//   Status      : digits, busy, done, err
// Modports: master = the environment (keypad, buttons, timer),
//           slave  = timer_loader itself.
interface timer_loader_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       stop;
  logic       zero;
`ifdef TIMER_LOADER_DOOR_EN
  logic       door_open;
`endif
  logic [3:0] data;
  logic       loadn;
  logic       clrn;
  logic       enable;
  logic [1:0] digits;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output key_valid, key_code, start, stop, zero,
`ifdef TIMER_LOADER_DOOR_EN
    output door_open,
`endif
    input  data, loadn, clrn, enable, digits, busy, done, err
  );

  modport slave (
    input  key_valid, key_code, start, stop, zero,
`ifdef TIMER_LOADER_DOOR_EN
    input  door_open,
`endif
    output data, loadn, clrn, enable, digits, busy, done, err
  );
endinterface

// File: rtl/timer_loader.sv
// timer_loader: keypad front end for the countdown timer. Decimal keys are
// shifted into the timer through data/loadn; the block also drives the
// timer's clrn and enable and watches zero to close a run.
// Ports:
//   clock - timer clock
//   clr   - synchronous active-high reset
//   bus   - timer_loader_if.slave (keys, start/stop, timer load/control,
//           status outputs digits/busy/done/err)
// Optional build macro TIMER_LOADER_DOOR_EN adds bus.door_open: an open door
// pauses a run and refuses start.
// All outputs come straight from flops.
module timer_loader #(
  parameter int MAX_DIGITS = 3,
  parameter int MAX_TENS   = 5
) (
  input  logic           clock,
  input  logic           clr,
  timer_loader_if.slave  bus
);

  localparam logic [1:0] MAX_DIG_L  = 2'(MAX_DIGITS);
  localparam logic [3:0] MAX_TENS_L = 4'(MAX_TENS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [3:0] data_r, data_s;
  logic       loadn_r, loadn_s;
  logic       clrn_r, clrn_s;
  logic       enable_r, enable_s;
  logic [1:0] digits_r, digits_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       err_r, err_s;
  // Shadow copy of what the timer holds, so start can be validated.
  logic [3:0] sh_mins_r, sh_mins_s;
  logic [3:0] sh_tens_r, sh_tens_s;
  logic [3:0] sh_ones_r, sh_ones_s;

  logic key_ok_s;
  logic entry_ok_s;
  logic door_s;

  assign key_ok_s   = bus.key_valid && (bus.key_code <= 4'd9);
  assign entry_ok_s = (sh_tens_r <= MAX_TENS_L) &&
                      ((sh_mins_r | sh_tens_r | sh_ones_r) != 4'd0);
`ifdef TIMER_LOADER_DOOR_EN
  assign door_s = bus.door_open;
`else
  assign door_s = 1'b0;
`endif

  // Next-state and next-output logic for the entry/run FSM.
  always_comb begin
    state_s   = state_r;
    data_s    = data_r;
    loadn_s   = 1'b1;
    clrn_s    = 1'b1;
    enable_s  = enable_r;
    digits_s  = digits_r;
    done_s    = 1'b0;
    err_s     = err_r;
    sh_mins_s = sh_mins_r;
    sh_tens_s = sh_tens_r;
    sh_ones_s = sh_ones_r;

    case (state_r)
      IDLE: begin
        enable_s = 1'b0;
        if (bus.start) begin
          // Nothing entered yet (digits is always 0 here).
          err_s = 1'b1;
        end else if (key_ok_s) begin
          data_s    = bus.key_code;
          loadn_s   = 1'b0;
          sh_mins_s = sh_tens_r;
          sh_tens_s = sh_ones_r;
          sh_ones_s = bus.key_code;
          digits_s  = digits_r + 2'd1;
          err_s     = 1'b0;
          state_s   = ENTRY;
        end else begin
          state_s = IDLE;
        end
      end

      ENTRY: begin
        // Priority: stop, then start, then key.
        if (bus.stop) begin
          clrn_s    = 1'b0;
          digits_s  = 2'd0;
          sh_mins_s = 4'd0;
          sh_tens_s = 4'd0;
          sh_ones_s = 4'd0;
          state_s   = IDLE;
        end else if (bus.start) begin
          if (door_s || !entry_ok_s) begin
            err_s = 1'b1;
          end else begin
            enable_s = 1'b1;
            state_s  = RUN;
          end
        end else if (key_ok_s) begin
          // Any legal key acknowledges a previous error, even when full.
          err_s = 1'b0;
          if (digits_r < MAX_DIG_L) begin
            data_s    = bus.key_code;
            loadn_s   = 1'b0;
            sh_mins_s = sh_tens_r;
            sh_tens_s = sh_ones_r;
            sh_ones_s = bus.key_code;
            digits_s  = digits_r + 2'd1;
          end else begin
            loadn_s = 1'b1;
          end
        end else begin
          state_s = ENTRY;
        end
      end

      RUN: begin
        // zero outranks door and stop so a finished run always reports done.
        if (bus.zero && enable_r) begin
          enable_s  = 1'b0;
          done_s    = 1'b1;
          digits_s  = 2'd0;
          sh_mins_s = 4'd0;
          sh_tens_s = 4'd0;
          sh_ones_s = 4'd0;
          state_s   = IDLE;
        end else if (door_s || bus.stop) begin
          enable_s = 1'b0;
          state_s  = PAUSE;
        end else begin
          enable_s = 1'b1;
        end
      end

      PAUSE: begin
        enable_s = 1'b0;
        if (bus.stop) begin
          clrn_s    = 1'b0;
          digits_s  = 2'd0;
          sh_mins_s = 4'd0;
          sh_tens_s = 4'd0;
          sh_ones_s = 4'd0;
          state_s   = IDLE;
        end else if (bus.start) begin
          if (door_s) begin
            err_s = 1'b1;
          end else begin
            enable_s = 1'b1;
            state_s  = RUN;
          end
        end else begin
          state_s = PAUSE;
        end
      end

      default: begin
        enable_s = 1'b0;
        state_s  = IDLE;
      end
    endcase

    busy_s = (state_s == RUN);
  end

  // State and output registers; clr forces the post-reset clear pulse.
  always_ff @(posedge clock) begin
    if (clr) begin
      state_r   <= IDLE;
      data_r    <= 4'd0;
      loadn_r   <= 1'b1;
      clrn_r    <= 1'b0;
      enable_r  <= 1'b0;
      digits_r  <= 2'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      sh_mins_r <= 4'd0;
      sh_tens_r <= 4'd0;
      sh_ones_r <= 4'd0;
    end else begin
      state_r   <= state_s;
      data_r    <= data_s;
      loadn_r   <= loadn_s;
      clrn_r    <= clrn_s;
      enable_r  <= enable_s;
      digits_r  <= digits_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      sh_mins_r <= sh_mins_s;
      sh_tens_r <= sh_tens_s;
      sh_ones_r <= sh_ones_s;
    end
  end

  assign bus.data   = data_r;
  assign bus.loadn  = loadn_r;
  assign bus.clrn   = clrn_r;
  assign bus.enable = enable_r;
  assign bus.digits = digits_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_r;

endmodule

// File: tb/tb_timer_loader.sv
// Directed bench for timer_loader with a small timer load-port model.
module tb_timer_loader;

  logic clock;
  logic clr;
  int   checks;
  int   errors;
  int   loadn_cnt;
  int   clrn_cnt;
  int   snap;
  logic [3:0] t_mins, t_tens, t_ones;

  timer_loader_if bus ();

  timer_loader #(.MAX_DIGITS(3), .MAX_TENS(5)) dut (
    .clock (clock),
    .clr   (clr),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model of the timer's load port plus pulse counters.
  always @(posedge clock) begin
    if (bus.clrn === 1'b0) begin
      t_mins <= 4'd0;
      t_tens <= 4'd0;
      t_ones <= 4'd0;
      clrn_cnt <= clrn_cnt + 1;
    end else if (bus.loadn === 1'b0) begin
      t_mins <= t_tens;
      t_tens <= t_ones;
      t_ones <= bus.data;
      loadn_cnt <= loadn_cnt + 1;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; loadn_cnt = 0; clrn_cnt = 0;
    clr = 1'b1;
    bus.key_valid = 1'b0; bus.key_code = 4'd0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.zero = 1'b0;
`ifdef TIMER_LOADER_DOOR_EN
    bus.door_open = 1'b0;
`endif
    tick();
    check_value("rst_clrn",   32'(bus.clrn),   32'd0);
    check_value("rst_loadn",  32'(bus.loadn),  32'd1);
    check_value("rst_data",   32'(bus.data),   32'd0);
    check_value("rst_enable", 32'(bus.enable), 32'd0);
    check_value("rst_digits", 32'(bus.digits), 32'd0);
    check_value("rst_busy",   32'(bus.busy),   32'd0);
    check_value("rst_done",   32'(bus.done),   32'd0);
    check_value("rst_err",    32'(bus.err),    32'd0);
    clr = 1'b0;
    tick();
    check_value("rst_clrn_rel", 32'(bus.clrn), 32'd1);
    loadn_cnt = 0;

    // 1: keys 1,3,0 then start.
    press(4'd1);
    check_value("t1_loadn1", 32'(bus.loadn), 32'd0);
    check_value("t1_data1",  32'(bus.data),  32'd1);
    press(4'd3);
    check_value("t1_data3",  32'(bus.data),  32'd3);
    press(4'd0);
    check_value("t1_data0",  32'(bus.data),  32'd0);
    check_value("t1_digits", 32'(bus.digits), 32'd3);
    pulse_start();
    check_value("t1_enable", 32'(bus.enable), 32'd1);
    check_value("t1_busy",   32'(bus.busy),   32'd1);
    check_value("t1_loads",  32'(loadn_cnt),  32'd3);
    check_value("t1_timer",  {20'd0, t_mins, t_tens, t_ones}, 32'h130);
    tick();
    check_value("t1_enable_hold", 32'(bus.enable), 32'd1);

    // 2: zero ends the run.
    bus.zero = 1'b1;
    tick();
    bus.zero = 1'b0;
    check_value("t2_enable", 32'(bus.enable), 32'd0);
    check_value("t2_done",   32'(bus.done),   32'd1);
    check_value("t2_digits", 32'(bus.digits), 32'd0);
    check_value("t2_busy",   32'(bus.busy),   32'd0);
    tick();
    check_value("t2_done_off", 32'(bus.done), 32'd0);

    // 3: bad sec_tens, then a key on a full entry clears err without loading.
    snap = loadn_cnt;
    press(4'd1); press(4'd7); press(4'd0);
    pulse_start();
    check_value("t3_err",    32'(bus.err),    32'd1);
    check_value("t3_enable", 32'(bus.enable), 32'd0);
    press(4'd5);
    check_value("t3_err_clr", 32'(bus.err),    32'd0);
    check_value("t3_loadn",   32'(bus.loadn),  32'd1);
    check_value("t3_digits",  32'(bus.digits), 32'd3);
    tick();
    check_value("t3_loads",   32'(loadn_cnt - snap), 32'd3);
    pulse_stop();
    check_value("t3_stop_clrn",   32'(bus.clrn),   32'd0);
    check_value("t3_stop_digits", 32'(bus.digits), 32'd0);
    tick();

    // 4: a fourth key is dropped.
    snap = loadn_cnt;
    press(4'd2); press(4'd0); press(4'd0); press(4'd9);
    check_value("t4_loadn4", 32'(bus.loadn), 32'd1);
    check_value("t4_loads",  32'(loadn_cnt - snap), 32'd3);
    check_value("t4_timer",  {20'd0, t_mins, t_tens, t_ones}, 32'h200);

    // 5: run, pause, resume, pause, clear.
    pulse_start();
    check_value("t5_run", 32'(bus.enable), 32'd1);
    pulse_stop();
    check_value("t5_pause_en",   32'(bus.enable), 32'd0);
    check_value("t5_pause_busy", 32'(bus.busy),   32'd0);
    press(4'd4);
    check_value("t5_pause_key", 32'(bus.loadn), 32'd1);
    pulse_start();
    check_value("t5_resume", 32'(bus.enable), 32'd1);
    pulse_stop();
    check_value("t5_pause2", 32'(bus.enable), 32'd0);
    snap = clrn_cnt;
    pulse_stop();
    check_value("t5_clrn",   32'(bus.clrn),   32'd0);
    check_value("t5_loadn",  32'(bus.loadn),  32'd1);
    check_value("t5_digits", 32'(bus.digits), 32'd0);
    tick();
    check_value("t5_clrn_rel", 32'(bus.clrn), 32'd1);
    check_value("t5_clrn_cnt", 32'(clrn_cnt - snap), 32'd1);

    // Edge cases: empty start, illegal code, start beats key, zero beats stop.
    pulse_start();
    check_value("e_empty_err", 32'(bus.err), 32'd1);
    press(4'd12);
    check_value("e_bad_loadn",  32'(bus.loadn),  32'd1);
    check_value("e_bad_err",    32'(bus.err),    32'd1);
    check_value("e_bad_digits", 32'(bus.digits), 32'd0);
    press(4'd4);
    check_value("e_key_loadn", 32'(bus.loadn), 32'd0);
    check_value("e_key_data",  32'(bus.data),  32'd4);
    check_value("e_key_err",   32'(bus.err),   32'd0);
    bus.key_code = 4'd7; bus.key_valid = 1'b1;
    pulse_start();
    bus.key_valid = 1'b0;
    check_value("e_prio_loadn",  32'(bus.loadn),  32'd1);
    check_value("e_prio_enable", 32'(bus.enable), 32'd1);
    check_value("e_prio_digits", 32'(bus.digits), 32'd1);
    bus.zero = 1'b1; bus.stop = 1'b1;
    tick();
    bus.zero = 1'b0; bus.stop = 1'b0;
    check_value("e_zs_done",   32'(bus.done),   32'd1);
    check_value("e_zs_enable", 32'(bus.enable), 32'd0);
    tick();

    // 6: clr mid-run at 0:45.
    press(4'd0); press(4'd4); press(4'd5);
    pulse_start();
    check_value("t6_run", 32'(bus.enable), 32'd1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_value("t6_enable", 32'(bus.enable), 32'd0);
    check_value("t6_clrn",   32'(bus.clrn),   32'd0);
    check_value("t6_done",   32'(bus.done),   32'd0);
    check_value("t6_err",    32'(bus.err),    32'd0);
    check_value("t6_digits", 32'(bus.digits), 32'd0);
    tick();
    check_value("t6_clrn_rel", 32'(bus.clrn), 32'd1);
    check_value("t6_done2",    32'(bus.done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
